// File: rtl/tawas_pkg.sv
// Shared Tawas types: thread/register widths, flag bit positions, writeback entry.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package tawas_pkg;

    localparam int THR_W       = 5;
    localparam int REG_W       = 3;
    localparam int DATA_W      = 32;
    localparam int FLAG_W      = 8;
    localparam int NUM_THREADS = 1 << THR_W;

    // Bit positions inside the 8-bit flags byte
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVFL = 2;

    typedef logic [THR_W-1:0]  thread_t;
    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [FLAG_W-1:0] flags_t;

    // Thread sits in the top bits so the FIFO can expose it as a per-entry tag
    typedef struct packed {
        thread_t            thread;
        reg_idx_t           rg;
        logic [DATA_W-1:0]  data;
    } wb_ent_t;

    localparam int WB_ENT_W = $bits(wb_ent_t);

    // One-hot thread decode used to build the load-pending mask
    function automatic logic [NUM_THREADS-1:0] thread_dec(input thread_t t);
        logic [NUM_THREADS-1:0] d;
        d    = '0;
        d[t] = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/tawas_wb_fifo.sv
// Synchronous FIFO with registered count; head is a combinational read of the array.
// Latency: push at edge N is visible at the head from cycle N+1 (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; per-entry valid/tag exported.
module tawas_wb_fifo #(
    parameter  int WIDTH = 40,
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 5,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] ent_vld,
    output logic [TAG_W-1:0] ent_tag [DEPTH]
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer/count next state; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until a push makes them valid
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    // An entry is live when its distance from the read pointer is below the count
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off        = AW'(i) - rd_ptr_q;
            ent_vld[i] = ({1'b0, off} < count_q);
            ent_tag[i] = mem_q[i][WIDTH-1 -: TAG_W];
        end
    end

endmodule

// File: rtl/tawas_wb_arb.sv
// Merges AU writebacks and queued load returns onto the single register-file write port; holds flags.
// Latency: AU 1 cycle; load return >= 2 cycles (one more per AU-busy cycle while it waits).
// Backpressure: AU never stalls; loads use en/ready with ready = registered FIFO count < LS_DEPTH.
module tawas_wb_arb
    import tawas_pkg::*;
#(
    parameter int LS_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_au_en,
    input  logic [THR_W-1:0]       wb_au_thread,
    input  logic [REG_W-1:0]       wb_au_reg,
    input  logic [DATA_W-1:0]      wb_au_data,
    input  logic                   wb_au_flags_en,
    input  logic [FLAG_W-1:0]      wb_au_flags,
    input  logic                   ls_rd_en,
    output logic                   ls_rd_ready,
    input  logic [THR_W-1:0]       ls_rd_thread,
    input  logic [REG_W-1:0]       ls_rd_reg,
    input  logic [DATA_W-1:0]      ls_rd_data,
    output logic                   rf_we,
    output logic [THR_W-1:0]       rf_thread,
    output logic [REG_W-1:0]       rf_reg,
    output logic [DATA_W-1:0]      rf_data,
    input  logic [THR_W-1:0]       flags_rd_thread,
    output logic [FLAG_W-1:0]      flags_rd,
    output logic [NUM_THREADS-1:0] ls_pend_mask
);

    localparam int AW = (LS_DEPTH > 1) ? $clog2(LS_DEPTH) : 1;
    localparam int CW = AW + 1;

    // FIFO interface
    wb_ent_t             push_ent, head_ent;
    logic [WB_ENT_W-1:0] head_raw;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full, fifo_empty;
    logic [LS_DEPTH-1:0] ent_vld;
    thread_t             ent_tag [LS_DEPTH];
    logic                ls_push, ls_pop;

    // Output stage, flags and pend mask state
    logic                   rf_we_q,     rf_we_d;
    thread_t                rf_thread_q, rf_thread_d;
    reg_idx_t               rf_reg_q,    rf_reg_d;
    logic [DATA_W-1:0]      rf_data_q,   rf_data_d;
    flags_t                 flags_q [NUM_THREADS];
    logic [NUM_THREADS-1:0] pend_q, pend_d;

    assign ls_rd_ready = (fifo_count < CW'(LS_DEPTH));
    assign ls_push     = ls_rd_en && !fifo_full;
    // AU always owns the port; loads only drain in AU bubbles
    assign ls_pop      = !wb_au_en && !fifo_empty;

    assign push_ent = '{thread: ls_rd_thread, rg: ls_rd_reg, data: ls_rd_data};
    assign head_ent = wb_ent_t'(head_raw);

    tawas_wb_fifo #(
        .WIDTH (WB_ENT_W),
        .DEPTH (LS_DEPTH),
        .TAG_W (THR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ls_push),
        .wdata   (push_ent),
        .pop     (ls_pop),
        .rdata   (head_raw),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ent_vld (ent_vld),
        .ent_tag (ent_tag)
    );

    // Select this cycle's writer; payload holds when idle so only rf_we matters then
    always_comb begin
        rf_we_d     = wb_au_en || ls_pop;
        rf_thread_d = rf_thread_q;
        rf_reg_d    = rf_reg_q;
        rf_data_d   = rf_data_q;
        if (wb_au_en) begin
            rf_thread_d = wb_au_thread;
            rf_reg_d    = wb_au_reg;
            rf_data_d   = wb_au_data;
        end else if (ls_pop) begin
            rf_thread_d = head_ent.thread;
            rf_reg_d    = head_ent.rg;
            rf_data_d   = head_ent.data;
        end
    end

    // Pend mask after this edge: live entries now (a popped head moves into the rf stage,
    // so it stays counted) plus this cycle's push; the previous rf-stage load retires.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < LS_DEPTH; i++) begin
            if (ent_vld[i]) pend_d = pend_d | thread_dec(ent_tag[i]);
        end
        if (ls_push) pend_d = pend_d | thread_dec(ls_rd_thread);
    end

    // Output stage and pend mask registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q     <= 1'b0;
            rf_thread_q <= '0;
            rf_reg_q    <= '0;
            rf_data_q   <= '0;
            pend_q      <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_thread_q <= rf_thread_d;
            rf_reg_q    <= rf_reg_d;
            rf_data_q   <= rf_data_d;
            pend_q      <= pend_d;
        end
    end

    // Per-thread condition flags, updated on the same edge as the rf capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_THREADS; i++) flags_q[i] <= '0;
        end else if (wb_au_flags_en) begin
            flags_q[wb_au_thread] <= wb_au_flags;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_thread    = rf_thread_q;
    assign rf_reg       = rf_reg_q;
    assign rf_data      = rf_data_q;
    assign flags_rd     = flags_q[flags_rd_thread];
    assign ls_pend_mask = pend_q;

endmodule
